// File: rtl/mdu_div.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div
// Brief    : Iterative restoring divider, signed/unsigned, with pipeline stall.
//            Define MDU_DIV_EARLY_ZERO_EN to finish divide-by-zero in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_dvd;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_b_zero;

  logic               w_accept;
  logic               w_early;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_sub;
  logic               w_fits;
  logic [WIDTH-1:0]   w_dvd_nxt;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic               w_last;
  logic [WIDTH-1:0]   w_q_fin;
  logic [WIDTH-1:0]   w_r_fin;

  assign w_accept = start & ~cancel;

`ifdef MDU_DIV_EARLY_ZERO_EN
  assign w_early = (b == '0);
`else
  assign w_early = 1'b0;
`endif

  assign w_a_neg = is_signed & a[WIDTH-1];
  assign w_b_neg = is_signed & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  // The remainder stays below the divisor, so only the trial value needs the
  // extra bit; the subtraction result always fits back into WIDTH bits.
  assign w_trial   = {r_rem, r_dvd[WIDTH-1]};
  assign w_fits    = (w_trial >= {1'b0, r_dvs});
  assign w_sub     = w_trial[WIDTH-1:0] - r_dvs;
  assign w_rem_nxt = w_fits ? w_sub : w_trial[WIDTH-1:0];
  assign w_dvd_nxt = {r_dvd[WIDTH-2:0], w_fits};
  assign w_last    = (r_cnt == c_CNT_W'(WIDTH - 1));

  // With b=0 the magnitude remainder is |a|, so re-applying the sign of a
  // gives back a unchanged, including the most-negative value.
  assign w_q_fin = r_b_zero ? '1 : (r_q_neg ? -w_dvd_nxt : w_dvd_nxt);
  assign w_r_fin = r_r_neg ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall       = 1'b1;
          w_state_nxt = w_early ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (cancel) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_b_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_early) begin
              quotient  <= '1;
              remainder <= a;
              div_zero  <= 1'b1;
            end else begin
              r_dvd    <= w_a_mag;
              r_dvs    <= w_b_mag;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_q_neg  <= w_a_neg ^ w_b_neg;
              r_r_neg  <= w_a_neg;
              r_b_zero <= (b == '0);
            end
          end
        end
        S_BUSY: begin
          if (!cancel) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
              quotient  <= w_q_fin;
              remainder <= w_r_fin;
              div_zero  <= r_b_zero;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
